// File: rtl/sevseg_pkg.sv
// Shared constants for the seven-segment bank: hex glyph table, register
// offsets relative to NUM_DIGITS, and the blank pattern (internal 1 = lit).
package sevseg_pkg;

    localparam int OFF_DECODE = 0;
    localparam int OFF_BLINK  = 1;
    localparam int OFF_DIV    = 2;
    localparam int OFF_BRIGHT = 3;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Index 0 is the rightmost entry; bit0 = segment a, bit6 = segment g.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/sevseg_hex_decode.sv
// Combinational nibble-to-glyph decode for one digit (0-F, b and d lowercase).
module sevseg_hex_decode
    import sevseg_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] segs
);

    assign segs = HEX_SEG[value];

endmodule

// File: rtl/sevseg_bank.sv
// Avalon-MM seven-segment register bank with per-digit decode and blink.
// Optional brightness PWM is compiled in when SEVSEG_DIM_EN is defined.
module sevseg_bank
    import sevseg_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int ADDR_W        = 5,
    parameter bit ACTIVE_LOW    = 1,
    parameter int BLINK_W       = 24,
    parameter int BLINK_DIV_RST = 12500000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_W-1:0]       address,
    input  logic                    chipselect,
    input  logic                    write_n,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    output logic [7*NUM_DIGITS-1:0] out_port
);

    localparam logic [ADDR_W-1:0] A_DECODE = ADDR_W'(NUM_DIGITS + OFF_DECODE);
    localparam logic [ADDR_W-1:0] A_BLINK  = ADDR_W'(NUM_DIGITS + OFF_BLINK);
    localparam logic [ADDR_W-1:0] A_DIV    = ADDR_W'(NUM_DIGITS + OFF_DIV);
    localparam logic [ADDR_W-1:0] A_BRIGHT = ADDR_W'(NUM_DIGITS + OFF_BRIGHT);
    localparam logic [7*NUM_DIGITS-1:0] OUT_OFF = {(7*NUM_DIGITS){ACTIVE_LOW}};

    logic [6:0]            digit [NUM_DIGITS];
    logic [6:0]            hex_seg [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] decode_mask;
    logic [NUM_DIGITS-1:0] blink_mask;
    logic [BLINK_W-1:0]    blink_div;
    logic [BLINK_W-1:0]    blink_cnt;
    logic                  phase;
    logic                  wr_en;
    logic                  wr_div;
    logic                  dim_on;
    logic [7*NUM_DIGITS-1:0] lit_all;
    logic [7*NUM_DIGITS-1:0] gated;
    logic                  unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign wr_div       = wr_en && (address == A_DIV);
    // Upper data bits are don't-care for every register.
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) digit[i] <= '0;
            decode_mask <= '0;
            blink_mask  <= '0;
            blink_div   <= BLINK_W'(BLINK_DIV_RST);
        end else if (wr_en) begin
            for (int i = 0; i < NUM_DIGITS; i++)
                if (address == ADDR_W'(i)) digit[i] <= writedata[6:0];
            if (address == A_DECODE) decode_mask <= writedata[NUM_DIGITS-1:0];
            if (address == A_BLINK)  blink_mask  <= writedata[NUM_DIGITS-1:0];
            if (address == A_DIV)    blink_div   <= writedata[BLINK_W-1:0];
        end
    end

    // A divider write restarts the blink cycle and overrides a coincident wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (wr_div || blink_div == '0) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_cnt == blink_div) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end

`ifdef SEVSEG_DIM_EN
    logic [3:0] pwm_cnt;
    logic [3:0] bright;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt <= 4'd0;
            bright  <= 4'hF;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
            if (wr_en && address == A_BRIGHT) bright <= writedata[3:0];
        end
    end

    assign dim_on = (pwm_cnt <= bright);
`else
    assign dim_on = 1'b1;
`endif

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        sevseg_hex_decode u_dec (
            .value(digit[g][3:0]),
            .segs (hex_seg[g])
        );
    end

    always_comb begin
        lit_all = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            lit_all[7*i +: 7] = (blink_mask[i] && phase) ? SEG_BLANK :
                                (decode_mask[i] ? hex_seg[i] : digit[i]);
    end

    assign gated = dim_on ? lit_all : '0;

    // Polarity is applied only here; everything upstream is 1 = lit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) out_port <= OUT_OFF;
        else       out_port <= gated ^ OUT_OFF;
    end

    always_comb begin
        readdata = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (address == ADDR_W'(i)) readdata[6:0] = digit[i];
        if (address == A_DECODE) readdata[NUM_DIGITS-1:0] = decode_mask;
        if (address == A_BLINK)  readdata[NUM_DIGITS-1:0] = blink_mask;
        if (address == A_DIV)    readdata[BLINK_W-1:0]    = blink_div;
`ifdef SEVSEG_DIM_EN
        if (address == A_BRIGHT) readdata[3:0] = bright;
`endif
    end

endmodule

// File: doc/sevseg_bank.md
Name: sevseg_bank

Overview:
- Parametrised Avalon-MM slave driving NUM_DIGITS seven-segment digits from one memory-mapped register bank.
- Successor to the single-digit PIO display port.
- Per-digit raw-segment or hex-decode mode, per-digit blink with a programmable prescaler, registered segment outputs.
- Sits on the system interconnect, as the single-digit ports do, and drives the board displays directly.

Parameters:
- NUM_DIGITS, 8: number of digits, 1..16.
- ADDR_W, 5: Avalon word-address width; must satisfy 2**ADDR_W >= NUM_DIGITS+4.
- ACTIVE_LOW, 1: 1 = segment lit when pin is 0 (board displays); 0 = lit when 1.
- BLINK_W, 24: width of the blink prescaler counter and divider register.
- BLINK_DIV_RST, 12500000: reset value of the divider register; fits in BLINK_W.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- address  in  ADDR_W  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data, zero-extended
- out_port  out  7*NUM_DIGITS  segments; digit i occupies [7i+6:7i], bit0=a ... bit6=g

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, port named reset.
- Write: occurs on a rising edge when chipselect=1 and write_n=0. No wait states.
- Read: readdata is combinational from address; no read side effects; unmapped addresses return 0.
- Register map (word address):
  - 0..N-1: DIGIT[i], 7 bits from writedata[6:0].
  - N: DECODE_MASK, N bits.
  - N+1: BLINK_MASK, N bits.
  - N+2: BLINK_DIV, BLINK_W bits.
  - N+3: BRIGHT, 4 bits.
  - Upper writedata bits are ignored; reads zero-extend.
- Reset values: DIGIT=0, DECODE_MASK=0, BLINK_MASK=0, BLINK_DIV=BLINK_DIV_RST, BRIGHT=15, blink counter=0, phase=0.
  - out_port is all segments off: all ones if ACTIVE_LOW, else all zeros.
- Digit source:
  - DECODE_MASK[i]=1: segments = hex table of DIGIT[i][3:0] (0-F, standard a-g patterns; b and d lowercase).
  - DECODE_MASK[i]=0: segments = DIGIT[i][6:0] raw.
  - Internal convention is 1 = lit; ACTIVE_LOW inverts only at the output register.
- Blink prescaler:
  - BLINK_DIV=0: counter held at 0, phase held at 0 (blink disabled).
  - Otherwise the counter increments each cycle. When it equals BLINK_DIV it wraps to 0 and phase toggles, so one phase lasts BLINK_DIV+1 cycles.
  - A write to BLINK_DIV forces counter=0 and phase=0 on the same edge. This write wins over a coincident wrap.
- Blanking: digit i is blanked (all segments off) when BLINK_MASK[i]=1 and phase=1.
- Output timing: out_port is registered. A register write at edge k appears on out_port at edge k+1. A phase toggle at edge k appears at edge k+1.
- Mid-operation reset: asynchronously returns every register, counter and output to its reset value; any in-flight write is lost.
- Simultaneous events: a write to DIGIT[i] in the same cycle as a phase toggle applies both; the output at k+1 reflects the new data and the new phase.

Optional Feature:
- Macro: SEVSEG_DIM_EN.
- Defined:
  - 4-bit free-running PWM counter, reset 0, wraps 15->0.
  - Lit segments are gated on only while pwm_cnt <= BRIGHT. BRIGHT=15 gives always on; BRIGHT=0 gives 1/16 duty.
  - Gating applies before the output register.
  - BRIGHT reads back its value.
- Undefined: no PWM logic; segments are never gated; BRIGHT address reads 0 and ignores writes.

Decomposition:
- Package sevseg_pkg:
  - Hex-to-segment constant table (16 x 7).
  - Register offset constants relative to NUM_DIGITS: DECODE, BLINK, DIV, BRIGHT.
  - Segment-blank constant.
- Sub-module sevseg_hex_decode: purely combinational 4-bit to 7-bit decode, instantiated once per digit. All state stays in sevseg_bank.

Test Plan:
- Reset:
  - Assert reset mid-cycle with ACTIVE_LOW=1 -> out_port all ones immediately.
  - Readback: BLINK_DIV=BLINK_DIV_RST, BRIGHT=15 (when SEVSEG_DIM_EN defined), all others 0.
- Raw vs decode:
  - Write DIGIT[2]=0x0A, DECODE_MASK=0 -> digit 2 lit pattern 0x0A.
  - Then DECODE_MASK=0x04 -> digit 2 shows "A", lit pattern 0x77, one cycle after the write.
- Blink:
  - BLINK_DIV=3, BLINK_MASK=0x01, DIGIT[0]=0x7F -> digit 0 alternates 4 cycles lit / 4 cycles blank.
  - Other digits unaffected.
  - BLINK_DIV=0 -> steady lit.
- Divider collision: write BLINK_DIV=5 on the exact cycle the counter hits its old divider -> counter=0, phase=0, no toggle.
- Readback/unmapped: write 0xFFFFFFFF to DIGIT[1] -> read 0x0000007F; read address N+4 -> 0; read with chipselect=0 has no effect.
- Dim (SEVSEG_DIM_EN): BRIGHT=3, DIGIT[0]=0x7F -> digit 0 lit 4 of every 16 cycles; BRIGHT=15 -> continuously lit.
